uart_tx_fifo_sched: RTL and testbench

- Scheduler around the shared 4-entry byte TX FIFO of the UART path.
- Front end: round-robin write arbiter that lets two byte producers share the single FIFO write port. Producer 0 is the RX loopback path; producer 1 is the local message source.
- Back end: drain sequencer that pops the FIFO and hands one byte at a time to the UART transmitter, with a programmable inter-byte gap.
- Also keeps a count of bytes transmitted.

---
 rtl/uart_tx_fifo_sched.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fifo_sched.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_sched.sv
// uart_tx_fifo_sched: shares the 4-entry UART TX FIFO between two producers
// and drains it one byte at a time into the transmitter.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   req0_valid/data/ready producer 0 (RX loopback), same-cycle handshake
//   req1_valid/data/ready producer 1 (local message source)
//   fifo_we, fifo_wdata   FIFO write port
//   fifo_full             FIFO full flag
//   fifo_re               FIFO pop
//   fifo_rdata            FIFO head byte (show-ahead)
//   fifo_empty            FIFO empty flag
//   tx_start              one-cycle start pulse to the transmitter
//   tx_data               registered byte for the transmitter
//   tx_busy, tx_done      transmitter status
//   sent_count            bytes handed to the transmitter since reset

module uart_tx_fifo_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  fifo_we,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_full,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic [CNT_WIDTH-1:0]  sent_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int GAP_LOAD_I =
    (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [7:0] GAP_LOAD = GAP_LOAD_I[7:0];

  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // ---------------- write arbiter ----------------
  logic last_grant;
  logic gnt0;
  logic gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    // Outputs stay quiet while reset is held, even
    // though the arbiter itself is combinational.
    if (!reset && !fifo_full) begin
      unique case (1'b1)
        (req0_valid && !req1_valid): gnt0 = 1'b1;
        (!req0_valid && req1_valid): gnt1 = 1'b1;
        (req0_valid && req1_valid): begin
          gnt0 = last_grant;
          gnt1 = !last_grant;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign fifo_we    = gnt0 | gnt1;
  assign fifo_wdata = gnt1 ? req1_data : req0_data;

  // Resets to 1 so producer 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end
  end

  // ---------------- drain sequencer ----------------
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] gap_cnt;
  logic [7:0] gap_nxt;
  logic       pop;

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    pop       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!reset && !fifo_empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) begin
          if (GAP_CYCLES == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_GAP;
            gap_nxt   = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == 8'd0) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap_cnt - 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign fifo_re  = pop;
  assign tx_start = (state == ST_START);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      gap_cnt    <= 8'd0;
      tx_data    <= '0;
      sent_count <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
      if (pop) begin
        tx_data    <= fifo_rdata;
        sent_count <= sent_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_sched.sv
// tb_uart_tx_fifo_sched: directed bench with a 4-entry FIFO model,
// a 10-cycle transmitter model and two queue-driven producers.

module tb_uart_tx_fifo_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       fifo_we;
  logic [7:0] fifo_wdata;
  logic       fifo_full;
  logic       fifo_re;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic [15:0] sent_count;

  logic hold_busy = 1'b0;
  logic inj_done = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_sched #(
    .DATA_WIDTH(8),
    .GAP_CYCLES(3),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req0_valid(req0_valid),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .fifo_we(fifo_we),
    .fifo_wdata(fifo_wdata),
    .fifo_full(fifo_full),
    .fifo_re(fifo_re),
    .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .sent_count(sent_count)
  );

  always @(posedge clk) cyc++;

  // FIFO model
  logic [7:0] fm [4];
  int fcnt;
  int rp;
  int wp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt <= 0;
      rp <= 0;
      wp <= 0;
    end else begin
      if (fifo_we && fcnt < 4) begin
        fm[wp] <= fifo_wdata;
        wp <= (wp + 1) % 4;
      end
      if (fifo_re && fcnt > 0) rp <= (rp + 1) % 4;
      fcnt <= fcnt + ((fifo_we && fcnt < 4) ? 1 : 0)
                   - ((fifo_re && fcnt > 0) ? 1 : 0);
    end
  end

  assign fifo_full = (fcnt == 4);
  assign fifo_empty = (fcnt == 0);
  assign fifo_rdata = fm[rp];

  // Transmitter model: done pulse 11 cycles after start
  logic m_busy;
  logic m_done;
  int m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      if (tx_start) begin
        m_busy <= 1'b1;
        m_cnt <= 10;
      end else if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end
  end

  assign tx_busy = m_busy | hold_busy;
  assign tx_done = m_done | inj_done;

  // Producers
  logic [7:0] p0_q[$];
  logic [7:0] p1_q[$];

  always @(posedge clk) begin
    if (req0_valid && req0_ready) void'(p0_q.pop_front());
    if (req1_valid && req1_ready) void'(p1_q.pop_front());
    #2;
    req0_valid = (p0_q.size() != 0);
    req0_data = req0_valid ? p0_q[0] : 8'h00;
    req1_valid = (p1_q.size() != 0);
    req1_data = req1_valid ? p1_q[0] : 8'h00;
  end

  // Monitors, sampled on the falling edge
  int we_cyc[$];
  int re_cyc[$];
  int st_cyc[$];
  int dn_cyc[$];
  logic [7:0] wr_log[$];
  logic [7:0] sent_log[$];
  int full_viol = 0;
  int start_viol = 0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (fifo_we) begin
        we_cyc.push_back(cyc);
        wr_log.push_back(fifo_wdata);
      end
      if (fifo_re) re_cyc.push_back(cyc);
      if (tx_start) begin
        st_cyc.push_back(cyc);
        sent_log.push_back(tx_data);
        if (prev_start) start_viol++;
      end
      if (tx_done) dn_cyc.push_back(cyc);
      if (fifo_full && (req0_ready || req1_ready || fifo_we))
        full_viol++;
    end
    prev_start = tx_start;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    we_cyc.delete();
    re_cyc.delete();
    st_cyc.delete();
    dn_cyc.delete();
    wr_log.delete();
    sent_log.delete();
    full_viol = 0;
    start_viol = 0;
  endtask

  task automatic begin_reset();
    step(1);
    reset = 1'b1;
    hold_busy = 1'b0;
    inj_done = 1'b0;
    p0_q.delete();
    p1_q.delete();
    step(2);
    clear_logs();
  endtask

  task automatic release_reset();
    step(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    p0_q.push_back(8'h41);
    step(2);
    n_total++;
    if (req0_ready !== 1'b0 || fifo_we !== 1'b0)
      $display("FAIL reset_arb: ready=%b we=%b want 0 0",
               req0_ready, fifo_we);
    else n_pass++;
    n_total++;
    if (fifo_re !== 1'b0 || tx_start !== 1'b0)
      $display("FAIL reset_drain: re=%b start=%b want 0 0",
               fifo_re, tx_start);
    else n_pass++;
    n_total++;
    if (tx_data !== 8'h00 || sent_count !== 16'd0)
      $display("FAIL reset_regs: data=%h cnt=%0d want 00 0",
               tx_data, sent_count);
    else n_pass++;
  endtask

  task automatic test_single();
    clear_logs();
    release_reset();
    step(20);
    n_total++;
    if (we_cyc.size() != 1 || re_cyc.size() != 1
        || st_cyc.size() != 1)
      $display("FAIL single_counts: we=%0d re=%0d st=%0d want 1 1 1",
               we_cyc.size(), re_cyc.size(), st_cyc.size());
    else n_pass++;
    n_total++;
    if (re_cyc[0] - we_cyc[0] != 1)
      $display("FAIL single_pop_lat: got %0d want 1",
               re_cyc[0] - we_cyc[0]);
    else n_pass++;
    n_total++;
    if (st_cyc[0] - re_cyc[0] != 1)
      $display("FAIL single_start_lat: got %0d want 1",
               st_cyc[0] - re_cyc[0]);
    else n_pass++;
    n_total++;
    if (sent_log[0] !== 8'h41)
      $display("FAIL single_data: got %h want 41", sent_log[0]);
    else n_pass++;
    n_total++;
    if (sent_count !== 16'd1)
      $display("FAIL single_count: got %0d want 1", sent_count);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [7:0] e;
    begin_reset();
    for (int i = 0; i < 4; i++) begin
      p0_q.push_back(8'hA0 + 8'(i));
      p1_q.push_back(8'hB0 + 8'(i));
    end
    release_reset();
    step(200);
    n_total++;
    if (wr_log.size() != 8)
      $display("FAIL rr_writes: got %0d want 8", wr_log.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      e = ((i % 2) == 0) ? 8'hA0 + 8'(i / 2) : 8'hB0 + 8'(i / 2);
      n_total++;
      if (wr_log[i] !== e)
        $display("FAIL rr_order[%0d]: got %h want %h", i, wr_log[i], e);
      else n_pass++;
    end
    n_total++;
    if (sent_log.size() != 8 || sent_log[7] !== 8'hB3)
      $display("FAIL rr_sent: n=%0d last=%h want 8 b3",
               sent_log.size(), sent_log[7]);
    else n_pass++;
    n_total++;
    if (sent_count !== 16'd8)
      $display("FAIL rr_count: got %0d want 8", sent_count);
    else n_pass++;
  endtask

  task automatic test_full_stall();
    begin_reset();
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) p0_q.push_back(8'hC0 + 8'(i));
    release_reset();
    step(200);
    n_total++;
    if (wr_log.size() != 4 || re_cyc.size() != 0)
      $display("FAIL full_accept: wr=%0d re=%0d want 4 0",
               wr_log.size(), re_cyc.size());
    else n_pass++;
    n_total++;
    if (req0_ready !== 1'b0 || req0_valid !== 1'b1)
      $display("FAIL full_ready: ready=%b valid=%b want 0 1",
               req0_ready, req0_valid);
    else n_pass++;
    hold_busy = 1'b0;
    step(150);
    n_total++;
    if (wr_log.size() != 6)
      $display("FAIL full_writes: got %0d want 6", wr_log.size());
    else n_pass++;
    n_total++;
    if (we_cyc[4] - re_cyc[0] != 1)
      $display("FAIL full_resume: got %0d want 1",
               we_cyc[4] - re_cyc[0]);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (sent_log[i] !== 8'hC0 + 8'(i))
        $display("FAIL full_sent[%0d]: got %h want %h",
                 i, sent_log[i], 8'hC0 + 8'(i));
      else n_pass++;
    end
    n_total++;
    if (full_viol != 0 || sent_count !== 16'd6)
      $display("FAIL full_misc: viol=%0d cnt=%0d want 0 6",
               full_viol, sent_count);
    else n_pass++;
  endtask

  task automatic test_gap();
    begin_reset();
    for (int i = 0; i < 3; i++) p1_q.push_back(8'hD0 + 8'(i));
    release_reset();
    step(80);
    n_total++;
    if (st_cyc.size() != 3 || dn_cyc.size() != 3)
      $display("FAIL gap_counts: st=%0d dn=%0d want 3 3",
               st_cyc.size(), dn_cyc.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (st_cyc[i + 1] - dn_cyc[i] != 5)
        $display("FAIL gap_space[%0d]: got %0d want 5",
                 i, st_cyc[i + 1] - dn_cyc[i]);
      else n_pass++;
    end
    n_total++;
    if (start_viol != 0)
      $display("FAIL gap_start_width: got %0d want 0", start_viol);
    else n_pass++;
    n_total++;
    if (sent_log[2] !== 8'hD2)
      $display("FAIL gap_data: got %h want d2", sent_log[2]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int guard;
    begin_reset();
    for (int i = 0; i < 3; i++) p0_q.push_back(8'hE0 + 8'(i));
    release_reset();
    guard = 0;
    while (st_cyc.size() == 0 && guard < 30) begin
      step(1);
      guard++;
    end
    n_total++;
    if (st_cyc.size() != 1)
      $display("FAIL mid_first_start: got %0d want 1", st_cyc.size());
    else n_pass++;
    step(3);
    n_total++;
    if (sent_count !== 16'd1)
      $display("FAIL mid_pre_count: got %0d want 1", sent_count);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (tx_start !== 1'b0 || fifo_re !== 1'b0 || fifo_we !== 1'b0
        || tx_data !== 8'h00 || sent_count !== 16'd0)
      $display("FAIL mid_reset_out: st=%b re=%b we=%b d=%h c=%0d want 0",
               tx_start, fifo_re, fifo_we, tx_data, sent_count);
    else n_pass++;
    step(2);
    p0_q.delete();
    clear_logs();
    reset = 1'b0;
    step(40);
    n_total++;
    if (st_cyc.size() != 0 || re_cyc.size() != 0)
      $display("FAIL mid_quiet: st=%0d re=%0d want 0 0",
               st_cyc.size(), re_cyc.size());
    else n_pass++;
    p0_q.push_back(8'hF0);
    step(25);
    n_total++;
    if (sent_log.size() != 1 || sent_log[0] !== 8'hF0)
      $display("FAIL mid_fresh: n=%0d d=%h want 1 f0",
               sent_log.size(), sent_log[0]);
    else n_pass++;
    n_total++;
    if (sent_count !== 16'd1)
      $display("FAIL mid_fresh_count: got %0d want 1", sent_count);
    else n_pass++;
  endtask

  task automatic test_spurious();
    int rel;
    begin_reset();
    release_reset();
    step(3);
    inj_done = 1'b1;
    step(1);
    inj_done = 1'b0;
    step(10);
    n_total++;
    if (re_cyc.size() != 0 || st_cyc.size() != 0
        || sent_count !== 16'd0)
      $display("FAIL spur_idle: re=%0d st=%0d c=%0d want 0 0 0",
               re_cyc.size(), st_cyc.size(), sent_count);
    else n_pass++;
    hold_busy = 1'b1;
    p0_q.push_back(8'h5A);
    step(4);
    inj_done = 1'b1;
    step(1);
    inj_done = 1'b0;
    step(6);
    n_total++;
    if (wr_log.size() != 1 || re_cyc.size() != 0
        || st_cyc.size() != 0)
      $display("FAIL spur_busy: wr=%0d re=%0d st=%0d want 1 0 0",
               wr_log.size(), re_cyc.size(), st_cyc.size());
    else n_pass++;
    hold_busy = 1'b0;
    rel = cyc;
    step(3);
    n_total++;
    if (re_cyc.size() != 1 || re_cyc[0] != rel)
      $display("FAIL spur_pop: n=%0d at=%0d want 1 at %0d",
               re_cyc.size(), re_cyc[0], rel);
    else n_pass++;
    n_total++;
    if (st_cyc[0] != rel + 1 || sent_log[0] !== 8'h5A)
      $display("FAIL spur_start: at=%0d d=%h want %0d 5a",
               st_cyc[0], sent_log[0], rel + 1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_gap();
    test_reset_mid();
    test_spurious();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
